line_window_buffer: RTL and testbench
=====================================

// Module: line_window_buffer
// PURPOSE
//  Parametrised sliding-window line buffer for the conv datapath.
//  Takes a raster pixel stream one pixel per handshake and holds KERNEL_LENGTH-1 line buffers.
//  Emits a full KERNEL_LENGTH x KERNEL_LENGTH window for every pixel where the window is complete.
//  Sits between the DMA read stream and the VRSM compute array.
// PARAMETERS
//  DATA_WIDTH     16  bits per pixel
//  KERNEL_LENGTH  3   window side K; >=2
//  LINE_WIDTH     8   pixels per image row W; >=K
// PORTS
//  clk        in   1            single clock, rising edge
//  rst_n      in   1            asynchronous, active-low reset
//  in_valid   in   1            din valid
//  in_ready   out  1            block can accept din
//  din        in   DATA_WIDTH   pixel, raster order
//  in_last    in   1            din is last pixel of frame
//  out_valid  out  1            dout holds a complete window
//  out_ready  in   1            consumer accepts dout
//  dout       out  [K-1:0][K-1:0][DATA_WIDTH]  window, dout[i][j]
//  frame_done out  1            one-cycle pulse, frame end accepted
//  frame_err  out  1            sticky; in_last arrived at col != W-1
// BEHAVIOUR
//  - Accept = in_valid && in_ready. in_ready = !out_valid || out_ready (combinational).
//  - Reset (async, rst_n=0): out_valid=0, dout=0, col=0, row=0, frame_done=0, frame_err=0.
//    Line-buffer RAM is not reset; its contents are masked by the row counter.
//  - Counters: col 0..W-1; row saturates at K-1.
//    On accept at col=W-1: col<=0, row<=min(row+1,K-1); otherwise col<=col+1.
//  - Column taps on accept at col c:
//    tap[K-1]=din; tap[k]=line[k][c] for k<K-1 (line[0] = oldest row).
//    Then line[k][c]<=tap[k+1], so rows shift up by one.
//  - Window: on accept, every dout[i][j]<=dout[i][j+1] for j<K-1, and dout[i][K-1]<=tap[i].
//    Window contents do not change without an accept.
//  - dout[i][j] is the pixel at (R-(K-1)+i, C-(K-1)+j), where (R,C) is the last accepted position.
//  - out_valid: set the cycle after an accept where row>=K-1 and col>=K-1 (pre-update values).
//    Cleared after an output handshake with no qualifying accept in the same cycle.
//    Latency: 1 cycle from accept to window.
//  - Backpressure: when out_valid=1 and out_ready=0, in_ready=0 and dout is held stable.
//    No pixel is dropped or duplicated.
//  - Simultaneous output handshake and qualifying accept: out_valid stays 1 and dout advances.
//  - Row wrap: windows straddling col 0 (col<K-1) are never flagged valid.
//  - in_last accepted: after the update, col<=0, row<=0 and frame_done pulses next cycle.
//    If col!=W-1 at that point, frame_err<=1; only reset clears it.
//    The next frame's first window is again at (K-1,K-1); no stale rows are emitted.
//  - in_last at (R,W-1) with R>=K-1: that final window is still emitted.
//  - Line buffers are W-deep RAMs indexed by col: one read and one write per accept, same address.
//    Read-before-write semantics are required.
// TESTING  (K=3, W=8, DATA_WIDTH=16, pixel=(row<<4)|col)
//  1. 4 rows streamed, out_ready=1, no gaps -> 12 windows total.
//     First window 1 cycle after accepting 0x22: dout[0][0]=0x00, dout[2][2]=0x22, dout[1][0]=0x10.
//  2. Hold out_ready=0 for 5 cycles while out_valid -> in_ready=0, dout unchanged.
//     On release the next window (R,C)=(2,3) has dout[2][2]=0x23; total count is unchanged.
//  3. in_valid toggling every other cycle -> window sequence identical to case 1.
//  4. in_last on pixel 0x37 -> frame_done=1 for exactly 1 cycle, frame_err=0.
//     The next frame emits its first window only after its (2,2) pixel.
//  5. in_last on pixel 0x14 -> frame_err=1, held through next frame; counters restart at (0,0).
//  6. rst_n low mid-row 3 with out_valid=1 -> out_valid=0 and dout=0 with no clock edge.
//     After release, 3 fresh rows give first window at (2,2) with values from the new data only.

Source files
------------

// File: rtl/line_window_buffer.sv
// Sliding KxK window generator over a raster pixel stream, using K-1 line RAMs
// indexed by column and a KxK shift register of column taps.
module line_window_buffer #(
   parameter int DATA_WIDTH    = 16,
   parameter int KERNEL_LENGTH = 3,
   parameter int LINE_WIDTH    = 8
) (
   input  logic                                                      clk,
   input  logic                                                      rst_n,
   input  logic                                                      in_valid,
   output logic                                                      in_ready,
   input  logic [DATA_WIDTH-1:0]                                     din,
   input  logic                                                      in_last,
   output logic                                                      out_valid,
   input  logic                                                      out_ready,
   output logic [KERNEL_LENGTH-1:0][KERNEL_LENGTH-1:0][DATA_WIDTH-1:0] dout,
   output logic                                                      frame_done,
   output logic                                                      frame_err
);

   localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam int RW = $clog2(KERNEL_LENGTH);
   localparam logic [CW-1:0] COL_LAST  = CW'(LINE_WIDTH - 1);
   localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL_LENGTH - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(KERNEL_LENGTH - 1);

   logic [CW-1:0]                                  col_r;
   logic [RW-1:0]                                  row_r;
   logic                                           accept_s;
   logic                                           qualify_s;
   logic [KERNEL_LENGTH-1:0][DATA_WIDTH-1:0]       tap_s;
   logic [DATA_WIDTH-1:0] line_mem [0:KERNEL_LENGTH-2][0:LINE_WIDTH-1];

   assign in_ready  = !out_valid || out_ready;
   assign accept_s  = in_valid && in_ready;
   // row_r saturates, so reaching ROW_LAST means K-1 real rows sit in the RAMs
   assign qualify_s = accept_s && (row_r == ROW_LAST) && (col_r >= COL_FIRST);

   // Column taps: stored rows at the current column plus the incoming pixel
   always_comb begin
      tap_s = '0;
      for (int k = 0; k < KERNEL_LENGTH - 1; k++) begin
         tap_s[k] = line_mem[k][col_r];
      end
      tap_s[KERNEL_LENGTH-1] = din;
   end

   // Line RAMs: read-before-write at the same column, rows shift up by one
   always_ff @(posedge clk) begin
      if (accept_s) begin
         for (int k = 0; k < KERNEL_LENGTH - 1; k++) begin
            line_mem[k][col_r] <= tap_s[k+1];
         end
      end
   end

   // Raster position counters and frame status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_r      <= '0;
         row_r      <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= accept_s && in_last;
         if (accept_s) begin
            if (in_last) begin
               col_r <= '0;
               row_r <= '0;
               if (col_r != COL_LAST) begin
                  frame_err <= 1'b1;
               end
            end else if (col_r == COL_LAST) begin
               col_r <= '0;
               if (row_r != ROW_LAST) begin
                  row_r <= row_r + RW'(1);
               end
            end else begin
               col_r <= col_r + CW'(1);
            end
         end
      end
   end

   // Window shift register and its valid flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout      <= '0;
         out_valid <= 1'b0;
      end else begin
         if (accept_s) begin
            for (int i = 0; i < KERNEL_LENGTH; i++) begin
               for (int j = 0; j < KERNEL_LENGTH - 1; j++) begin
                  dout[i][j] <= dout[i][j+1];
               end
               dout[i][KERNEL_LENGTH-1] <= tap_s[i];
            end
         end
         if (qualify_s) begin
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_line_window_buffer.sv
// Self-checking bench for line_window_buffer: directed table, corner sequences
// and randomized traffic checked against an image-array reference model.
module tb_line_window_buffer;
   localparam int DW = 16;
   localparam int K  = 3;
   localparam int W  = 8;
   localparam int WB = K * K * DW;

   typedef logic [K-1:0][K-1:0][DW-1:0] win_t;
   typedef struct {
      logic          v;
      logic [DW-1:0] d;
      logic          last;
      logic          rdy;
      logic          ev;
      logic [DW-1:0] e00;
      logic [DW-1:0] e10;
      logic [DW-1:0] e22;
      logic          edone;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] din = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   win_t          dout;
   logic          frame_done;
   logic          frame_err;

   line_window_buffer #(.DATA_WIDTH(DW), .KERNEL_LENGTH(K), .LINE_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .din(din), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .dout(dout), .frame_done(frame_done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   win_count = 0;
   int   wc0;
   win_t q[$];
   logic [DW-1:0] img [0:15][0:W-1];
   int   mr = 0;
   int   mc = 0;
   logic exp_done = 1'b0;
   logic exp_err = 1'b0;
   vec_t tbl[32];

   function automatic logic [DW-1:0] pix(input int r, input int c);
      return DW'((r << 4) | c);
   endfunction

   task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // One clock: drive at negedge, check pre-edge outputs, advance the model, wait next negedge
   task automatic step(input logic v, input logic [DW-1:0] d, input logic last, input logic rdy);
      logic acc;
      logic hs;
      win_t w;
      in_valid = v; din = d; in_last = last; out_ready = rdy;
      #1;
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      chk("in_ready", in_ready, !out_valid || out_ready);
      chk("out_valid", out_valid, q.size() != 0);
      if (out_valid && q.size() != 0) chk("window", dout, q[0]);
      chk("frame_done", frame_done, exp_done);
      chk("frame_err", frame_err, exp_err);
      exp_done = acc && last;
      if (hs && q.size() != 0) begin
         void'(q.pop_front());
         win_count++;
      end
      if (acc) begin
         img[mr][mc] = d;
         if (mr >= K - 1 && mc >= K - 1) begin
            for (int i = 0; i < K; i++)
               for (int j = 0; j < K; j++)
                  w[i][j] = img[mr-(K-1)+i][mc-(K-1)+j];
            q.push_back(w);
         end
         if (last) begin
            if (mc != W - 1) exp_err = 1'b1;
            mr = 0; mc = 0;
         end else if (mc == W - 1) begin
            mc = 0; mr++;
         end else begin
            mc++;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         tbl[i].v    = 1'b1;
         tbl[i].d    = pix(i / W, i % W);
         tbl[i].last = (i == 31);
         tbl[i].rdy  = 1'b1;
         tbl[i].ev   = (i / W >= 2) && (i % W >= 2);
         tbl[i].e00  = tbl[i].ev ? pix(i / W - 2, i % W - 2) : 16'h0000;
         tbl[i].e10  = tbl[i].ev ? pix(i / W - 1, i % W - 2) : 16'h0000;
         tbl[i].e22  = pix(i / W, i % W);
         tbl[i].edone = (i == 31);
      end

      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_dout", dout, '0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_frame_err", frame_err, 1'b0);
      rst_n = 1'b1;

      // 4 full rows, no gaps, frame ends on 0x37
      wc0 = win_count;
      for (int i = 0; i < 32; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].last, tbl[i].rdy);
         chk("t1_valid", out_valid, tbl[i].ev);
         if (tbl[i].ev) begin
            chk("t1_d00", dout[0][0], tbl[i].e00);
            chk("t1_d10", dout[1][0], tbl[i].e10);
            chk("t1_d22", dout[2][2], tbl[i].e22);
         end
         chk("t1_done", frame_done, tbl[i].edone);
         if (i == 18) begin
            chk("t1_first_d00", dout[0][0], 16'h0000);
            chk("t1_first_d22", dout[2][2], 16'h0022);
            chk("t1_first_d10", dout[1][0], 16'h0010);
         end
      end
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("t1_done_pulse", frame_done, 1'b0);
      chk("t1_windows", win_count - wc0, 12);
      chk("t1_err", frame_err, 1'b0);

      // backpressure hold at window (2,2)
      wc0 = win_count;
      for (int i = 0; i < 19; i++) step(1'b1, pix(i / W, i % W), 1'b0, 1'b1);
      chk("t2_first", dout[2][2], 16'h0022);
      for (int n = 0; n < 5; n++) begin
         step(1'b1, 16'h0023, 1'b0, 1'b0);
         chk("t2_in_ready", in_ready, 1'b0);
         chk("t2_hold_valid", out_valid, 1'b1);
         chk("t2_hold_d22", dout[2][2], 16'h0022);
         chk("t2_hold_d00", dout[0][0], 16'h0000);
      end
      step(1'b1, 16'h0023, 1'b0, 1'b1);
      chk("t2_release_d22", dout[2][2], 16'h0023);
      for (int i = 20; i < 32; i++) step(1'b1, pix(i / W, i % W), i == 31, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("t2_windows", win_count - wc0, 12);

      // in_valid toggling; in_last on idle cycles must be ignored
      wc0 = win_count;
      for (int i = 0; i < 32; i++) begin
         step(1'b0, 16'hdead, 1'b1, 1'b1);
         step(1'b1, pix(i / W, i % W), i == 31, 1'b1);
      end
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("t3_windows", win_count - wc0, 12);
      chk("t3_err", frame_err, 1'b0);

      // early in_last on 0x14, then a fresh frame
      for (int i = 0; i < 13; i++) step(1'b1, pix(i / W, i % W), i == 12, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("t5_err_set", frame_err, 1'b1);
      wc0 = win_count;
      for (int i = 0; i < 24; i++) step(1'b1, pix(i / W, i % W), i == 23, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("t5_err_sticky", frame_err, 1'b1);
      chk("t5_windows", win_count - wc0, 6);

      // async reset mid-row 3 with a window pending
      for (int i = 0; i < 28; i++) step(1'b1, pix(i / W, i % W), 1'b0, 1'b1);
      chk("t6_pre_valid", out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", out_valid, 1'b0);
      chk("t6_rst_dout", dout, '0);
      chk("t6_rst_err", frame_err, 1'b0);
      q.delete();
      mr = 0; mc = 0; exp_done = 1'b0; exp_err = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wc0 = win_count;
      for (int i = 0; i < 24; i++) begin
         step(1'b1, 16'h8000 | pix(i / W, i % W), i == 23, 1'b1);
         if (i == 18) begin
            chk("t6_first_d22", dout[2][2], 16'h8022);
            chk("t6_first_d00", dout[0][0], 16'h8000);
         end
      end
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("t6_windows", win_count - wc0, 6);

      // randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         logic v;
         logic r;
         logic l;
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 3) != 0);
         l = (mr == 12 && mc == W - 1) ? 1'b1 : ($urandom_range(0, 59) == 0);
         step(v, DW'($urandom), l, r);
      end
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("rand_drained", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
